// File: rtl/triangle_voice_scheduler.sv
// Time-shares one registered triangle LUT among NUM_VOICES voices.
// On each sample tick it sums the volume-scaled voice samples into one saturated mix sample.
module triangle_voice_scheduler #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PHASE_W    = 24
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sample_tick,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
  input  logic [PHASE_W-1:0]            cfg_inc,
  input  logic [7:0]                    cfg_vol,
  input  logic                          cfg_en,
  input  logic                          cfg_phase_rst,
  output logic [8:0]                    lut_addr,
  input  logic signed [15:0]            lut_data,
  output logic signed [15:0]            mix_out,
  output logic                          mix_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int unsigned IW = $clog2(NUM_VOICES);
  localparam int unsigned AW = 17 + IW;
  localparam logic signed [AW-1:0] SatHi = AW'(32767);
  localparam logic signed [AW-1:0] SatLo = AW'(-32768);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOut} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [8:0]               lut_addr_q, lut_addr_d;
  logic signed [15:0]       mix_out_q, mix_out_d;
  logic                     mix_valid_q, mix_valid_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic [PHASE_W-1:0]       phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]       phase_d [NUM_VOICES];
  logic [PHASE_W-1:0]       inc_q   [NUM_VOICES];
  logic [PHASE_W-1:0]       inc_d   [NUM_VOICES];
  logic [7:0]               vol_q   [NUM_VOICES];
  logic [7:0]               vol_d   [NUM_VOICES];
  logic [NUM_VOICES-1:0]    en_q, en_d;
  // Volume/enable travel with the issued address: s1 while the LUT reads, s2 when data returns.
  logic                     s1_valid_q, s1_valid_d, s1_en_q, s1_en_d;
  logic [7:0]               s1_vol_q, s1_vol_d;
  logic                     s2_valid_q, s2_valid_d, s2_en_q, s2_en_d;
  logic [7:0]               s2_vol_q, s2_vol_d;

  logic                     issue;
  logic [IW-1:0]            issue_idx;
  logic signed [24:0]       prod;
  logic signed [AW-1:0]     term;

  always_comb begin
    prod = lut_data * $signed({1'b0, s2_vol_q});
    term = s2_en_q ? {{(AW-17){prod[24]}}, prod[24:8]} : '0;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    lut_addr_d  = lut_addr_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    phase_d     = phase_q;
    inc_d       = inc_q;
    vol_d       = vol_q;
    en_d        = en_q;
    s1_valid_d  = 1'b0;
    s1_vol_d    = s1_vol_q;
    s1_en_d     = s1_en_q;
    s2_valid_d  = s1_valid_q;
    s2_vol_d    = s1_vol_q;
    s2_en_d     = s1_en_q;
    issue       = 1'b0;
    issue_idx   = idx_q;

    if (s2_valid_q) acc_d = acc_q + term;
    if (sample_tick && busy_q) overrun_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (sample_tick) begin
          issue     = 1'b1;
          issue_idx = '0;
          idx_d     = IW'(1);
          acc_d     = '0;
          busy_d    = 1'b1;
          state_d   = (NUM_VOICES > 1) ? StIssue : StDrain;
        end
      end
      StIssue: begin
        issue = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NUM_VOICES - 1)) state_d = StDrain;
      end
      StDrain: begin
        // Last term lands on the edge where the s1 stage has emptied.
        if (!s1_valid_q) state_d = StOut;
      end
      StOut: begin
        if (acc_q > SatHi)      mix_out_d = 16'sh7fff;
        else if (acc_q < SatLo) mix_out_d = 16'sh8000;
        else                    mix_out_d = acc_q[15:0];
        mix_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      lut_addr_d = phase_q[issue_idx][PHASE_W-1 -: 9];
      s1_valid_d = 1'b1;
      s1_vol_d   = vol_q[issue_idx];
      s1_en_d    = en_q[issue_idx];
    end

    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (issue && issue_idx == IW'(v) && en_q[v]) phase_d[v] = phase_q[v] + inc_q[v];
      if (cfg_we && cfg_voice == IW'(v)) begin
        inc_d[v] = cfg_inc;
        vol_d[v] = cfg_vol;
        en_d[v]  = cfg_en;
        if (cfg_phase_rst) phase_d[v] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      acc_q       <= '0;
      lut_addr_q  <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      en_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_vol_q    <= '0;
      s1_en_q     <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_vol_q    <= '0;
      s2_en_q     <= 1'b0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= '0;
        inc_q[v]   <= '0;
        vol_q[v]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      lut_addr_q  <= lut_addr_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      en_q        <= en_d;
      s1_valid_q  <= s1_valid_d;
      s1_vol_q    <= s1_vol_d;
      s1_en_q     <= s1_en_d;
      s2_valid_q  <= s2_valid_d;
      s2_vol_q    <= s2_vol_d;
      s2_en_q     <= s2_en_d;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= phase_d[v];
        inc_q[v]   <= inc_d[v];
        vol_q[v]   <= vol_d[v];
      end
    end
  end

  assign lut_addr  = lut_addr_q;
  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_triangle_voice_scheduler.sv
// Randomized bench for triangle_voice_scheduler: a registered triangle LUT model plus a
// per-sample reference that sums voices directly from the phase/volume rules.
module tb_triangle_voice_scheduler;

  localparam int N  = 4;
  localparam int PW = 24;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               sample_tick = 1'b0;
  logic               cfg_we = 1'b0;
  logic [1:0]         cfg_voice = '0;
  logic [PW-1:0]      cfg_inc = '0;
  logic [7:0]         cfg_vol = '0;
  logic               cfg_en = 1'b0;
  logic               cfg_phase_rst = 1'b0;
  logic [8:0]         lut_addr;
  logic signed [15:0] lut_data = '0;
  logic signed [15:0] mix_out;
  logic               mix_valid;
  logic               busy;
  logic               overrun;

  always #5 clk = ~clk;

  triangle_voice_scheduler #(.NUM_VOICES(N), .PHASE_W(PW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_tick  (sample_tick),
    .cfg_we       (cfg_we),
    .cfg_voice    (cfg_voice),
    .cfg_inc      (cfg_inc),
    .cfg_vol      (cfg_vol),
    .cfg_en       (cfg_en),
    .cfg_phase_rst(cfg_phase_rst),
    .lut_addr     (lut_addr),
    .lut_data     (lut_data),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Triangle: 0 at 0, peak near 128, 0 at 256, trough at 384.
  function automatic int tri_val(input int a);
    int r;
    if (a < 128)      r = a * 256;
    else if (a < 384) r = (256 - a) * 256;
    else              r = (a - 512) * 256;
    if (r > 32767) r = 32767;
    return r;
  endfunction

  always @(posedge clk) lut_data <= 16'(tri_val(int'(lut_addr)));

  int unsigned m_phase [N];
  int unsigned m_inc   [N];
  int          m_vol   [N];
  bit          m_en    [N];
  bit          m_ovr;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_phase[v] = 0;
      m_inc[v]   = 0;
      m_vol[v]   = 0;
      m_en[v]    = 1'b0;
    end
    m_ovr = 1'b0;
  endtask

  task automatic cfg_write(input int v, input int unsigned inc, input int vol, input bit en,
                           input bit prst);
    cfg_we        = 1'b1;
    cfg_voice     = 2'(v);
    cfg_inc       = PW'(inc);
    cfg_vol       = 8'(vol);
    cfg_en        = en;
    cfg_phase_rst = prst;
    @(posedge clk);
    #1;
    cfg_we        = 1'b0;
    cfg_phase_rst = 1'b0;
    m_inc[v] = inc & 32'h00ff_ffff;
    m_vol[v] = vol & 255;
    m_en[v]  = en;
    if (prst) m_phase[v] = 0;
  endtask

  // One full sample; inject_at in 1..N+2 raises a stray tick before that edge (0 = none).
  task automatic run_seq(input int inject_at);
    int exp_addr [N];
    int sum;
    sum = 0;
    for (int v = 0; v < N; v++) begin
      exp_addr[v] = int'((m_phase[v] >> 15) & 511);
      if (m_en[v]) begin
        sum += (tri_val(exp_addr[v]) * m_vol[v]) >>> 8;
        m_phase[v] = (m_phase[v] + m_inc[v]) & 32'h00ff_ffff;
      end
    end
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;

    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    check_eq("busy_start", busy, 1);
    check_eq("addr_v0", lut_addr, exp_addr[0]);
    for (int e = 1; e <= N + 2; e++) begin
      if (e == inject_at) begin
        sample_tick = 1'b1;
        m_ovr = 1'b1;
      end
      @(posedge clk);
      #1;
      sample_tick = 1'b0;
      if (e < N) check_eq("addr_vk", lut_addr, exp_addr[e]);
      if (e < N + 2) check_eq("valid_early", mix_valid, 0);
    end
    check_eq("mix_valid", mix_valid, 1);
    check_eq("mix_out", longint'($signed(mix_out)), sum);
    check_eq("busy_end", busy, 0);
    check_eq("overrun", overrun, m_ovr);
  endtask

  task automatic idle_cycles(input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (mix_valid) cnt++;
    end
    check_eq("no_extra_valid", cnt, 0);
  endtask

  initial begin
    model_reset();
    #12;
    check_eq("rst_mix_out", mix_out, 0);
    check_eq("rst_valid", mix_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_addr", lut_addr, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single voice: step to address 64, then 64 -> 65.
    cfg_write(0, 64 << 15, 128, 1'b1, 1'b1);
    run_seq(0);
    cfg_write(0, 1 << 15, 128, 1'b1, 1'b0);
    run_seq(0);
    idle_cycles(1);
    run_seq(0);

    // Saturation: all voices at 127 then 383 with full volume.
    for (int v = 0; v < N; v++) cfg_write(v, 127 << 15, 255, 1'b1, 1'b1);
    run_seq(0);
    for (int v = 0; v < N; v++) cfg_write(v, 0, 255, 1'b1, 1'b0);
    run_seq(0);
    for (int v = 0; v < N; v++) cfg_write(v, 256 << 15, 255, 1'b1, 1'b0);
    run_seq(0);
    run_seq(0);

    // Disabled voice holds phase; phase reset restarts at address 0.
    cfg_write(1, 5 << 15, 200, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_seq(0);
    cfg_write(2, 3 << 15, 100, 1'b1, 1'b1);
    run_seq(0);

    // Back-to-back: tick in the mix_valid cycle.
    idle_cycles(1);
    run_seq(0);
    run_seq(0);

    // Overrun: stray tick mid-sequence is dropped.
    idle_cycles(1);
    run_seq(2);
    idle_cycles(N + 4);

    // Asynchronous reset mid-sequence.
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_mix_out", mix_out, 0);
    check_eq("arst_addr", lut_addr, 0);
    check_eq("arst_overrun", overrun, 0);
    check_eq("arst_valid", mix_valid, 0);
    model_reset();
    #3;
    reset_n = 1'b1;
    idle_cycles(12);

    // Randomized config and sequences.
    for (int it = 0; it < 30; it++) begin
      int nw;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++)
        cfg_write(int'($urandom_range(0, N - 1)), $urandom_range(0, 32'h00ff_ffff),
                  int'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) == 0));
      run_seq(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N + 2)) : 0);
      if ($urandom_range(0, 1) == 1) idle_cycles(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
